tamper_response_ctrl: RTL and testbench
=======================================

TAMPER_RESPONSE_CTRL -- requirements
Module: tamper_response_ctrl

Interface
REQ-001 Parameter DEBOUNCE_CYCLES, 4: consecutive synchronized-high cycles that qualify a critical error level (range 1-15).
REQ-002 Parameter FAIL_THRESHOLD, 3: accepted DETECT_FAIL events that escalate to zeroize (range 1-15).
REQ-003 Parameter FLAG_CLR_CYCLES, 8: low-pulse length of TAMPER_FLAG_RESET_N (range 1-255).
REQ-004 CLK  in  1  single clock; all state changes on its rising edge.
REQ-005 RESET_N  in  1  reset, asynchronous assert, active-low.
REQ-006 TAMPER_CHANGE_STROBE  in  1  asynchronous event strobe from tamper macro.
REQ-007 DETECT_CATEGORY  in  4  category of current event, valid with strobe.
REQ-008 DETECT_ATTEMPT  in  1  attempt flag, valid with strobe.
REQ-009 DETECT_FAIL  in  1  failed-attempt flag, valid with strobe.
REQ-010 DIGEST_ERROR, SC_ROM_DIGEST_ERROR, MESH_SHORT_ERROR  in  1 each  critical error levels.
REQ-011 JTAG_ACTIVE  in  1  JTAG activity level.
REQ-012 ARM  in  1  enables protective responses; when 0, events are recorded only.
REQ-013 CLEAR  in  1  single-cycle software acknowledge.
REQ-014 LOCKDOWN_ALL_N, DISABLE_ALL_IOS_N, ZEROIZE_N  out  1 each  active-low controls to tamper macro.
REQ-015 TAMPER_FLAG_RESET_N  out  1  active-low clear of macro's latched flags.
REQ-016 STATE  out  2  IDLE=0, LOCKDOWN=1, ZEROIZE=2, FLAG_CLR=3.
REQ-017 EVENT_COUNT  out  8  accepted strobe events; LAST_CATEGORY  out  4  category of the last accepted event; IRQ  out  1  sticky event indication.

Function
REQ-018 All asynchronous inputs pass a 2-flop synchronizer; strobe event = rising edge of the synchronized strobe; category/attempt/fail are captured from synchronized values on that same cycle.
REQ-019 Latency: input first sampled high at edge N -> STATE and all outputs update at edge N+2, all outputs registered.
REQ-020 Critical = any synchronized critical error high for DEBOUNCE_CYCLES consecutive cycles; the debounce counter clears on any low cycle.
REQ-021 Strobe accepted in IDLE, LOCKDOWN, ZEROIZE; ignored (not counted) in FLAG_CLR.
REQ-022 Accepted strobe: EVENT_COUNT +1, saturating at 255; LAST_CATEGORY loaded; IRQ set; if DETECT_FAIL, 4-bit fail counter +1, saturating at 15.
REQ-023 IDLE -> ZEROIZE when ARM and (critical, or fail counter reaches FAIL_THRESHOLD).
REQ-024 IDLE -> LOCKDOWN when ARM and (accepted strobe with DETECT_FAIL or DETECT_ATTEMPT, or synchronized JTAG_ACTIVE high); ZEROIZE condition takes priority.
REQ-025 LOCKDOWN -> ZEROIZE on ZEROIZE condition (ARM required); else LOCKDOWN -> FLAG_CLR on CLEAR; escalation wins over simultaneous CLEAR.
REQ-026 ZEROIZE is terminal; exit only by RESET_N; CLEAR ignored.
REQ-027 FLAG_CLR: fail counter and IRQ cleared on entry; TAMPER_FLAG_RESET_N low for exactly FLAG_CLR_CYCLES cycles, then -> IDLE with it high.
REQ-028 Outputs: IDLE/FLAG_CLR all controls high; LOCKDOWN LOCKDOWN_ALL_N=0, DISABLE_ALL_IOS_N=0; ZEROIZE all three low.
REQ-029 ARM=0: no state transition out of IDLE; counters, LAST_CATEGORY, IRQ still update; CLEAR in IDLE clears IRQ and fail counter without entering FLAG_CLR.
REQ-030 ARM deassertion in LOCKDOWN or ZEROIZE does not release outputs.

Reset
REQ-031 While RESET_N low: STATE=IDLE, LOCKDOWN_ALL_N=DISABLE_ALL_IOS_N=ZEROIZE_N=1, TAMPER_FLAG_RESET_N=1, EVENT_COUNT=0, LAST_CATEGORY=0, IRQ=0, fail and debounce counters 0, synchronizers 0.
REQ-032 Reset asserted mid-FLAG_CLR or mid-ZEROIZE returns immediately to reset values; no partial pulse continues after release.

Verification
REQ-033 ARM=1, strobe with DETECT_FAIL=1, CATEGORY=5 -> 2 edges later STATE=1, LOCKDOWN_ALL_N=0, EVENT_COUNT=1, LAST_CATEGORY=5, IRQ=1.
REQ-034 In LOCKDOWN, CLEAR pulse -> STATE=3, TAMPER_FLAG_RESET_N low exactly 8 cycles, then STATE=0, all controls high, IRQ=0.
REQ-035 ARM=1, three fail strobes -> third gives STATE=2, ZEROIZE_N=0; CLEAR then has no effect; RESET_N low restores all reset values.
REQ-036 MESH_SHORT_ERROR high 3 cycles then low -> no transition; high 4 cycles -> STATE=2.
REQ-037 ARM=0, 300 strobes -> EVENT_COUNT=255, STATE=0, all controls high.
REQ-038 In LOCKDOWN, fail-count threshold reached in same cycle as CLEAR -> STATE=2.

Source files
------------

// File: rtl/tamper_response_ctrl.sv
// Tamper response controller.
// Synchronizes the tamper macro's event and error signals, keeps event and
// failure statistics, and drives the macro's active-low lockdown, IO-disable,
// zeroize and flag-clear controls from a four-state response FSM.
// All outputs are registered. An input first sampled at edge N reaches the
// outputs at edge N+2.
module tamper_response_ctrl #(
  parameter int unsigned DEBOUNCE_CYCLES = 4,  // 1..15
  parameter int unsigned FAIL_THRESHOLD  = 3,  // 1..15
  parameter int unsigned FLAG_CLR_CYCLES = 8   // 1..255
) (
  input  logic       CLK,
  input  logic       RESET_N,
  input  logic       TAMPER_CHANGE_STROBE,
  input  logic [3:0] DETECT_CATEGORY,
  input  logic       DETECT_ATTEMPT,
  input  logic       DETECT_FAIL,
  input  logic       DIGEST_ERROR,
  input  logic       SC_ROM_DIGEST_ERROR,
  input  logic       MESH_SHORT_ERROR,
  input  logic       JTAG_ACTIVE,
  input  logic       ARM,
  input  logic       CLEAR,
  output logic       LOCKDOWN_ALL_N,
  output logic       DISABLE_ALL_IOS_N,
  output logic       ZEROIZE_N,
  output logic       TAMPER_FLAG_RESET_N,
  output logic [1:0] STATE,
  output logic [7:0] EVENT_COUNT,
  output logic [3:0] LAST_CATEGORY,
  output logic       IRQ
);

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_LOCKDOWN = 2'd1,
    ST_ZEROIZE  = 2'd2,
    ST_FLAG_CLR = 2'd3
  } state_e;

  localparam logic [3:0] DEB_LIM  = 4'(DEBOUNCE_CYCLES - 1);
  localparam logic [3:0] FAIL_TH  = 4'(FAIL_THRESHOLD);
  localparam logic [7:0] CLR_INIT = 8'(FLAG_CLR_CYCLES - 1);
  localparam int         SW       = 13;

  // Every input, including ARM and CLEAR, goes through the same synchronizer
  // so that all of them see the same two-edge latency.
  logic [SW-1:0] async_in;
  logic [SW-1:0] sync1_q, sync2_q;
  logic          strobe_prev_q;

  assign async_in = {CLEAR, ARM, JTAG_ACTIVE, MESH_SHORT_ERROR,
                     SC_ROM_DIGEST_ERROR, DIGEST_ERROR, DETECT_FAIL,
                     DETECT_ATTEMPT, DETECT_CATEGORY, TAMPER_CHANGE_STROBE};

  logic       s_strobe, s_attempt, s_fail, s_jtag, s_arm, s_clear;
  logic [3:0] s_cat;
  logic       any_crit;

  assign s_strobe  = sync2_q[0];
  assign s_cat     = sync2_q[4:1];
  assign s_attempt = sync2_q[5];
  assign s_fail    = sync2_q[6];
  assign any_crit  = |sync2_q[9:7];
  assign s_jtag    = sync2_q[10];
  assign s_arm     = sync2_q[11];
  assign s_clear   = sync2_q[12];

  // Two-flop synchronizer plus the previous strobe value for edge detection.
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      sync1_q       <= '0;
      sync2_q       <= '0;
      strobe_prev_q <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments let sync2_q take the old sync1_q;
      // blocking ones would collapse the two stages into one.
      sync1_q       <= async_in;
      sync2_q       <= sync1_q;
      strobe_prev_q <= s_strobe;
    end
  end

  state_e     state_q, state_d;
  logic [7:0] evt_q, evt_d;
  logic [3:0] cat_q, cat_d;
  logic       irq_q, irq_d;
  logic [3:0] fail_q, fail_d, fail_inc;
  logic [3:0] deb_q, deb_d;
  logic [7:0] clr_cnt_q, clr_cnt_d;
  logic       flag_rst_n_q, flag_rst_n_d;
  logic       lockdown_n_q, lockdown_n_d;
  logic       disable_n_q, disable_n_d;
  logic       zeroize_n_q, zeroize_n_d;

  logic strobe_rise, accept, critical, zero_cond, lock_cond;

  assign strobe_rise = s_strobe & ~strobe_prev_q;
  assign accept      = strobe_rise && (state_q != ST_FLAG_CLR);
  assign critical    = any_crit && (deb_q >= DEB_LIM);
  assign fail_inc    = (accept && s_fail && (fail_q != 4'hF)) ? fail_q + 4'd1 : fail_q;
  assign zero_cond   = s_arm && (critical || (fail_inc >= FAIL_TH));
  assign lock_cond   = s_arm && ((accept && (s_fail || s_attempt)) || s_jtag);

  // Next-state logic: event bookkeeping, debounce, FSM and control decode.
  always_comb begin
    // NOTE: every variable gets a default here so no path infers a latch.
    state_d      = state_q;
    evt_d        = evt_q;
    cat_d        = cat_q;
    irq_d        = irq_q;
    fail_d       = fail_q;
    clr_cnt_d    = clr_cnt_q;
    flag_rst_n_d = 1'b1;
    deb_d        = any_crit ? ((deb_q == 4'hF) ? deb_q : deb_q + 4'd1) : 4'd0;

    if (accept) begin
      evt_d  = (evt_q == 8'hFF) ? evt_q : evt_q + 8'd1;
      cat_d  = s_cat;
      irq_d  = 1'b1;
      fail_d = fail_inc;
    end

    case (state_q)
      ST_IDLE: begin
        if (zero_cond)      state_d = ST_ZEROIZE;
        else if (lock_cond) state_d = ST_LOCKDOWN;
        // CLEAR acknowledges here without a flag-clear pulse.
        if (s_clear) begin
          irq_d  = 1'b0;
          fail_d = 4'd0;
        end
      end
      ST_LOCKDOWN: begin
        // Escalation wins over a simultaneous CLEAR.
        if (zero_cond) begin
          state_d = ST_ZEROIZE;
        end else if (s_clear) begin
          state_d      = ST_FLAG_CLR;
          irq_d        = 1'b0;
          fail_d       = 4'd0;
          clr_cnt_d    = CLR_INIT;
          flag_rst_n_d = 1'b0;
        end
      end
      ST_ZEROIZE: begin
        // Terminal: only RESET_N leaves this state.
      end
      ST_FLAG_CLR: begin
        if (clr_cnt_q == 8'd0) begin
          state_d = ST_IDLE;
        end else begin
          clr_cnt_d    = clr_cnt_q - 8'd1;
          flag_rst_n_d = 1'b0;
        end
      end
    endcase

    lockdown_n_d = !((state_d == ST_LOCKDOWN) || (state_d == ST_ZEROIZE));
    disable_n_d  = lockdown_n_d;
    zeroize_n_d  = (state_d != ST_ZEROIZE);
  end

  // FSM state, counters and registered outputs.
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      state_q      <= ST_IDLE;
      evt_q        <= 8'd0;
      cat_q        <= 4'd0;
      irq_q        <= 1'b0;
      fail_q       <= 4'd0;
      deb_q        <= 4'd0;
      clr_cnt_q    <= 8'd0;
      flag_rst_n_q <= 1'b1;
      lockdown_n_q <= 1'b1;
      disable_n_q  <= 1'b1;
      zeroize_n_q  <= 1'b1;
    end else begin
      state_q      <= state_d;
      evt_q        <= evt_d;
      cat_q        <= cat_d;
      irq_q        <= irq_d;
      fail_q       <= fail_d;
      deb_q        <= deb_d;
      clr_cnt_q    <= clr_cnt_d;
      flag_rst_n_q <= flag_rst_n_d;
      lockdown_n_q <= lockdown_n_d;
      disable_n_q  <= disable_n_d;
      zeroize_n_q  <= zeroize_n_d;
    end
  end

  assign STATE               = state_q;
  assign EVENT_COUNT         = evt_q;
  assign LAST_CATEGORY       = cat_q;
  assign IRQ                 = irq_q;
  assign LOCKDOWN_ALL_N      = lockdown_n_q;
  assign DISABLE_ALL_IOS_N   = disable_n_q;
  assign ZEROIZE_N           = zeroize_n_q;
  assign TAMPER_FLAG_RESET_N = flag_rst_n_q;

endmodule

// File: tb/tb_tamper_response_ctrl.sv
// Directed bench for tamper_response_ctrl with default parameters
// (debounce 4, fail threshold 3, flag-clear pulse 8 cycles).
module tb_tamper_response_ctrl;

  logic       CLK = 1'b0;
  logic       RESET_N = 1'b0;
  logic       TAMPER_CHANGE_STROBE = 1'b0;
  logic [3:0] DETECT_CATEGORY = 4'd0;
  logic       DETECT_ATTEMPT = 1'b0;
  logic       DETECT_FAIL = 1'b0;
  logic       DIGEST_ERROR = 1'b0;
  logic       SC_ROM_DIGEST_ERROR = 1'b0;
  logic       MESH_SHORT_ERROR = 1'b0;
  logic       JTAG_ACTIVE = 1'b0;
  logic       ARM = 1'b0;
  logic       CLEAR = 1'b0;
  logic       LOCKDOWN_ALL_N, DISABLE_ALL_IOS_N, ZEROIZE_N, TAMPER_FLAG_RESET_N;
  logic [1:0] STATE;
  logic [7:0] EVENT_COUNT;
  logic [3:0] LAST_CATEGORY;
  logic       IRQ;

  int checks = 0;
  int failures = 0;

  always #5 CLK = ~CLK;

  tamper_response_ctrl dut (
    .CLK                  (CLK),
    .RESET_N              (RESET_N),
    .TAMPER_CHANGE_STROBE (TAMPER_CHANGE_STROBE),
    .DETECT_CATEGORY      (DETECT_CATEGORY),
    .DETECT_ATTEMPT       (DETECT_ATTEMPT),
    .DETECT_FAIL          (DETECT_FAIL),
    .DIGEST_ERROR         (DIGEST_ERROR),
    .SC_ROM_DIGEST_ERROR  (SC_ROM_DIGEST_ERROR),
    .MESH_SHORT_ERROR     (MESH_SHORT_ERROR),
    .JTAG_ACTIVE          (JTAG_ACTIVE),
    .ARM                  (ARM),
    .CLEAR                (CLEAR),
    .LOCKDOWN_ALL_N       (LOCKDOWN_ALL_N),
    .DISABLE_ALL_IOS_N    (DISABLE_ALL_IOS_N),
    .ZEROIZE_N            (ZEROIZE_N),
    .TAMPER_FLAG_RESET_N  (TAMPER_FLAG_RESET_N),
    .STATE                (STATE),
    .EVENT_COUNT          (EVENT_COUNT),
    .LAST_CATEGORY        (LAST_CATEGORY),
    .IRQ                  (IRQ)
  );

  task automatic check(input string tag, input int unsigned obs, input int unsigned exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // State plus the four active-low controls.
  task automatic check_ctrl(input string tag, input int unsigned st, input int unsigned lk,
                            input int unsigned ds, input int unsigned zr, input int unsigned fr);
    check({tag, ".state"}, 32'(STATE), st);
    check({tag, ".lockdown_n"}, 32'(LOCKDOWN_ALL_N), lk);
    check({tag, ".disable_n"}, 32'(DISABLE_ALL_IOS_N), ds);
    check({tag, ".zeroize_n"}, 32'(ZEROIZE_N), zr);
    check({tag, ".flag_rst_n"}, 32'(TAMPER_FLAG_RESET_N), fr);
  endtask

  task automatic check_stats(input string tag, input int unsigned ev, input int unsigned cat,
                             input int unsigned irq);
    check({tag, ".event_count"}, 32'(EVENT_COUNT), ev);
    check({tag, ".last_cat"}, 32'(LAST_CATEGORY), cat);
    check({tag, ".irq"}, 32'(IRQ), irq);
  endtask

  // Advance n rising edges and settle 1 time unit past the last one.
  task automatic tick(input int n);
    repeat (n) begin
      @(posedge CLK);
      #1;
    end
  endtask

  // One strobe event: high 2 cycles, low 2 cycles; fully accepted on return.
  task automatic strobe(input logic [3:0] cat, input logic att, input logic fl);
    DETECT_CATEGORY      = cat;
    DETECT_ATTEMPT       = att;
    DETECT_FAIL          = fl;
    TAMPER_CHANGE_STROBE = 1'b1;
    tick(2);
    TAMPER_CHANGE_STROBE = 1'b0;
    tick(2);
  endtask

  initial begin
    // Reset values while RESET_N is held low.
    tick(3);
    check_ctrl("reset", 0, 1, 1, 1, 1);
    check_stats("reset", 0, 0, 0);
    RESET_N = 1'b1;
    ARM     = 1'b1;
    tick(3);

    // Fail strobe, category 5: LOCKDOWN exactly two edges after first sample.
    DETECT_CATEGORY      = 4'd5;
    DETECT_FAIL          = 1'b1;
    TAMPER_CHANGE_STROBE = 1'b1;
    tick(2);
    check("lat_strobe.state", 32'(STATE), 0);
    tick(1);
    check_ctrl("fail_strobe", 1, 0, 0, 1, 1);
    check_stats("fail_strobe", 1, 5, 1);
    TAMPER_CHANGE_STROBE = 1'b0;
    DETECT_FAIL          = 1'b0;
    tick(3);

    // CLEAR in LOCKDOWN: 8-cycle flag-clear pulse; strobe during it is ignored.
    CLEAR = 1'b1;
    tick(1);
    CLEAR = 1'b0;
    tick(1);
    check("lat_clear.state", 32'(STATE), 1);
    tick(1);
    check_ctrl("flag_clr_entry", 3, 1, 1, 1, 0);
    check("flag_clr_entry.irq", 32'(IRQ), 0);
    DETECT_CATEGORY      = 4'd7;
    DETECT_ATTEMPT       = 1'b1;
    TAMPER_CHANGE_STROBE = 1'b1;
    tick(2);
    TAMPER_CHANGE_STROBE = 1'b0;
    DETECT_ATTEMPT       = 1'b0;
    tick(5);
    check_ctrl("flag_clr_last", 3, 1, 1, 1, 0);
    tick(1);
    check_ctrl("flag_clr_exit", 0, 1, 1, 1, 1);
    check_stats("flag_clr_exit", 1, 5, 0);

    // Three fail strobes escalate to ZEROIZE (fail count was cleared above).
    strobe(4'd2, 1'b0, 1'b1);
    check("fail1.state", 32'(STATE), 1);
    strobe(4'd3, 1'b0, 1'b1);
    check("fail2.state", 32'(STATE), 1);
    DETECT_CATEGORY      = 4'd9;
    DETECT_FAIL          = 1'b1;
    TAMPER_CHANGE_STROBE = 1'b1;
    tick(2);
    check("fail3_lat.state", 32'(STATE), 1);
    tick(1);
    check_ctrl("fail3", 2, 0, 0, 0, 1);
    check_stats("fail3", 4, 9, 1);
    TAMPER_CHANGE_STROBE = 1'b0;
    DETECT_FAIL          = 1'b0;
    tick(2);

    // ZEROIZE ignores CLEAR and ARM deassertion.
    CLEAR = 1'b1;
    tick(1);
    CLEAR = 1'b0;
    tick(4);
    check_ctrl("zero_clear", 2, 0, 0, 0, 1);
    ARM = 1'b0;
    tick(4);
    check_ctrl("zero_disarm", 2, 0, 0, 0, 1);

    // Asynchronous reset from ZEROIZE, checked before any clock edge.
    RESET_N = 1'b0;
    #1;
    check_ctrl("zero_reset", 0, 1, 1, 1, 1);
    check_stats("zero_reset", 0, 0, 0);
    tick(1);
    RESET_N = 1'b1;
    tick(2);
    check_ctrl("post_reset", 0, 1, 1, 1, 1);

    // Debounce: 3 high cycles ignored, 4 high cycles escalate.
    ARM = 1'b1;
    tick(3);
    MESH_SHORT_ERROR = 1'b1;
    tick(3);
    MESH_SHORT_ERROR = 1'b0;
    tick(6);
    check("mesh3.state", 32'(STATE), 0);
    MESH_SHORT_ERROR = 1'b1;
    tick(4);
    MESH_SHORT_ERROR = 1'b0;
    tick(1);
    check("mesh4_early.state", 32'(STATE), 0);
    tick(1);
    check_ctrl("mesh4", 2, 0, 0, 0, 1);
    RESET_N = 1'b0;
    ARM     = 1'b0;
    tick(2);
    RESET_N = 1'b1;
    tick(2);

    // JTAG activity locks down only when armed; disarm keeps LOCKDOWN.
    JTAG_ACTIVE = 1'b1;
    tick(4);
    check("jtag_disarmed.state", 32'(STATE), 0);
    ARM = 1'b1;
    tick(2);
    check("jtag_lat.state", 32'(STATE), 0);
    tick(1);
    check_ctrl("jtag_armed", 1, 0, 0, 1, 1);
    JTAG_ACTIVE = 1'b0;
    ARM         = 1'b0;
    tick(4);
    check_ctrl("lock_disarm", 1, 0, 0, 1, 1);
    RESET_N = 1'b0;
    tick(1);
    RESET_N = 1'b1;
    tick(2);

    // Disarmed: 300 fail+attempt strobes, event counter saturates at 255.
    for (int i = 0; i < 200; i++) strobe(4'(i), 1'b1, 1'b1);
    check("ev200.event_count", 32'(EVENT_COUNT), 200);
    for (int i = 200; i < 300; i++) strobe(4'(i), 1'b1, 1'b1);
    check_ctrl("ev300", 0, 1, 1, 1, 1);
    check_stats("ev300", 255, 11, 1);

    // CLEAR in IDLE clears IRQ and the fail counter without a flag pulse.
    CLEAR = 1'b1;
    tick(1);
    CLEAR = 1'b0;
    tick(2);
    check_ctrl("idle_clear", 0, 1, 1, 1, 1);
    check("idle_clear.irq", 32'(IRQ), 0);
    ARM = 1'b1;
    tick(4);
    check("arm_after_clear.state", 32'(STATE), 0);

    // Threshold reached together with CLEAR in LOCKDOWN: escalation wins.
    strobe(4'd1, 1'b1, 1'b0);
    check("attempt.state", 32'(STATE), 1);
    strobe(4'd2, 1'b0, 1'b1);
    strobe(4'd3, 1'b0, 1'b1);
    check("two_fails.state", 32'(STATE), 1);
    DETECT_CATEGORY      = 4'd4;
    DETECT_FAIL          = 1'b1;
    TAMPER_CHANGE_STROBE = 1'b1;
    CLEAR                = 1'b1;
    tick(1);
    CLEAR = 1'b0;
    tick(2);
    check_ctrl("esc_vs_clear", 2, 0, 0, 0, 1);
    check_stats("esc_vs_clear", 255, 4, 1);
    TAMPER_CHANGE_STROBE = 1'b0;
    tick(2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
